// File: rtl/dice_score_keeper.sv
// Score keeper for the dice game controller: display digits, dice sum, outcome LEDs and tallies.
// Optional consecutive-win streak counter enabled by defining DICE_STREAK_EN.
module dice_score_keeper #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roll_i,
  input  logic             result_i,
  input  logic [2:0]       diceout1_i,
  input  logic [2:0]       diceout2_i,
  output logic [6:0]       seg1_o,
  output logic [6:0]       seg2_o,
  output logic [3:0]       sum_out_o,
  output logic [2:0]       throws_o,
  output logic [CNT_W-1:0] win_count_o,
  output logic [CNT_W-1:0] loss_count_o,
  output logic [CNT_W-1:0] games_o,
  output logic             win_led_o,
  output logic             loss_led_o,
  output logic             game_done_o,
  output logic             busy_o,
  output logic             bad_die_o,
`ifdef DICE_STREAK_EN
  output logic [3:0]       streak_o,
`endif
  output logic [1:0]       state_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, SCORE = 2'd2, SHOW = 2'd3} state_t;

  state_t           state_q;
  logic             roll_q, roll_prev_q, result_q;
  logic [2:0]       d1_q, d2_q, d1_prev_q, d2_prev_q;
  logic [6:0]       seg1_q, seg2_q;
  logic [3:0]       sum_q;
  logic             bad_q;
  logic [2:0]       throws_q;
  logic [CNT_W-1:0] win_q, loss_q, games_q;
  logic             win_led_q, loss_led_q, game_done_q, busy_q;
  logic [HW-1:0]    hold_q;
  logic [3:0]       streak_q;
  logic             rise, fall, dice_chg;

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd1:    seg_of = 7'b0000110;
      3'd2:    seg_of = 7'b1011011;
      3'd3:    seg_of = 7'b1001111;
      3'd4:    seg_of = 7'b1100110;
      3'd5:    seg_of = 7'b1101101;
      3'd6:    seg_of = 7'b1111101;
      default: seg_of = 7'b1000000;
    endcase
  endfunction

  assign rise     = roll_q & ~roll_prev_q;
  assign fall     = ~roll_q & roll_prev_q;
  assign dice_chg = {d1_q, d2_q} != {d1_prev_q, d2_prev_q};

  // Input stage plus free-running display path; display follows the dice in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      roll_q <= 1'b0; roll_prev_q <= 1'b0; result_q <= 1'b0;
      d1_q <= '0; d2_q <= '0; d1_prev_q <= '0; d2_prev_q <= '0;
      seg1_q <= '0; seg2_q <= '0; sum_q <= '0; bad_q <= 1'b0;
    end else begin
      roll_q      <= roll_i;
      roll_prev_q <= roll_q;
      result_q    <= result_i;
      d1_q        <= diceout1_i;
      d2_q        <= diceout2_i;
      d1_prev_q   <= d1_q;
      d2_prev_q   <= d2_q;
      seg1_q      <= seg_of(d1_q);
      seg2_q      <= seg_of(d2_q);
      sum_q       <= {1'b0, d1_q} + {1'b0, d2_q};
      bad_q       <= (d1_q == 3'd0) || (d1_q == 3'd7) || (d2_q == 3'd0) || (d2_q == 3'd7);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; throws_q <= '0; win_q <= '0; loss_q <= '0; games_q <= '0;
      win_led_q <= 1'b0; loss_led_q <= 1'b0; game_done_q <= 1'b0; busy_q <= 1'b0;
      hold_q <= '0; streak_q <= '0;
    end else begin
      game_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q  <= PLAY;
            throws_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        PLAY: begin
          if (dice_chg && throws_q != 3'd7) throws_q <= throws_q + 3'd1;
          if (fall) begin
            state_q     <= SCORE;
            game_done_q <= 1'b1;
          end
        end
        SCORE: begin
          if (games_q != '1) games_q <= games_q + 1'b1;
          if (result_q) begin
            if (win_q != '1) win_q <= win_q + 1'b1;
            if (streak_q != 4'd15) streak_q <= streak_q + 4'd1;
          end else begin
            if (loss_q != '1) loss_q <= loss_q + 1'b1;
            streak_q <= '0;
          end
          win_led_q  <= result_q;
          loss_led_q <= ~result_q;
          hold_q     <= HW'(HOLD_CYCLES - 1);
          state_q    <= SHOW;
          busy_q     <= 1'b0;
        end
        SHOW: begin
          // A new game pre-empts the remaining hold window, including the final cycle.
          if (rise) begin
            win_led_q <= 1'b0; loss_led_q <= 1'b0;
            throws_q  <= '0;
            state_q   <= PLAY;
            busy_q    <= 1'b1;
          end else if (hold_q == '0) begin
            win_led_q <= 1'b0; loss_led_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg1_o       = seg1_q;
  assign seg2_o       = seg2_q;
  assign sum_out_o    = sum_q;
  assign bad_die_o    = bad_q;
  assign throws_o     = throws_q;
  assign win_count_o  = win_q;
  assign loss_count_o = loss_q;
  assign games_o      = games_q;
  assign win_led_o    = win_led_q;
  assign loss_led_o   = loss_led_q;
  assign game_done_o  = game_done_q;
  assign busy_o       = busy_q;
  assign state_o      = state_q;
`ifdef DICE_STREAK_EN
  assign streak_o     = streak_q;
`else
  logic unused_streak;
  assign unused_streak = ^streak_q;
`endif

endmodule
